// File: rtl/video_checker_pkg.sv
// Shared types and constants for the AXI4-Stream video frame checker.
package video_checker_pkg;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } state_e;

  localparam int ERR_NO_SOF    = 0;
  localparam int ERR_EARLY_SOF = 1;
  localparam int ERR_LINE_LEN  = 2;
  localparam int ERR_BITS      = 3;

endpackage

// File: rtl/video_frame_checksum.sv
// Per-frame tdata accumulator; the running sum restarts on SOF and is published at frame end.
module video_frame_checksum #(
  parameter int DATA_WIDTH = 24
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  beat_i,
  input  logic                  sof_i,
  input  logic                  frame_end_i,
  input  logic [DATA_WIDTH-1:0] tdata_i,
  output logic [31:0]           checksum_o
);

  logic [31:0] acc_q;
  logic [31:0] checksum_q;
  logic [31:0] sum;

  // Sum including the current beat, so a 1x1 frame publishes its own pixel.
  assign sum        = (sof_i ? 32'd0 : acc_q) + 32'(tdata_i);
  assign checksum_o = checksum_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc_q      <= '0;
      checksum_q <= '0;
    end else begin
      if (beat_i)      acc_q      <= sum;
      if (frame_end_i) checksum_q <= sum;
    end
  end

endmodule

// File: rtl/video_axi4s_frame_checker.sv
// AXI4-Stream video frame checker: counts frames, flags SOF/line-length errors.
// Optional checksum enabled by defining VIDEO_FRAME_CHECKER_CHECKSUM_EN.
module video_axi4s_frame_checker
  import video_checker_pkg::*;
#(
  parameter int TUSER_WIDTH = 1,
  parameter int DATA_WIDTH  = 24,
  parameter int X_WIDTH     = 12,
  parameter int Y_WIDTH     = 12,
  parameter int FRAME_WIDTH = 32
) (
  input  logic                   aresetn,
  input  logic                   aclk,
  input  logic                   aclken,
  input  logic [X_WIDTH-1:0]     param_width,
  input  logic [Y_WIDTH-1:0]     param_height,
  input  logic                   clear_err,
  input  logic [TUSER_WIDTH-1:0] s_axi4s_tuser,
  input  logic                   s_axi4s_tlast,
  input  logic [DATA_WIDTH-1:0]  s_axi4s_tdata,
  input  logic                   s_axi4s_tvalid,
  output logic                   s_axi4s_tready,
  output logic                   frame_done,
  output logic [FRAME_WIDTH-1:0] frame_count,
  output logic [2:0]             err_status,
  output logic [31:0]            frame_checksum
);

  state_e                 state_q, state_d;
  logic [X_WIDTH-1:0]     x_q, x_d, w_q, w_d, x_cur, w_cur;
  logic [Y_WIDTH-1:0]     y_q, y_d, h_q, h_d, y_cur, h_cur;
  logic                   tready_q, done_q;
  logic [FRAME_WIDTH-1:0] count_q;
  logic [ERR_BITS-1:0]    err_q, err_d, err_set;
  logic                   beat, sof, line_beat, frame_end;

  assign beat = aclken & s_axi4s_tvalid & tready_q;
  assign sof  = s_axi4s_tuser[0];

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    w_d       = w_q;
    h_d       = h_q;
    x_cur     = x_q;
    y_cur     = y_q;
    w_cur     = w_q;
    h_cur     = h_q;
    err_set   = '0;
    line_beat = 1'b0;
    frame_end = 1'b0;
    if (beat) begin
      if (sof) begin
        if (state_q == ACTIVE) err_set[ERR_EARLY_SOF] = 1'b1;
        // The SOF beat is pixel 1 of line 0 against the freshly latched geometry.
        w_cur     = param_width;
        h_cur     = param_height;
        x_cur     = X_WIDTH'(1);
        y_cur     = '0;
        w_d       = param_width;
        h_d       = param_height;
        x_d       = X_WIDTH'(1);
        y_d       = '0;
        state_d   = ACTIVE;
        line_beat = 1'b1;
      end else if (state_q == WAIT_SOF) begin
        err_set[ERR_NO_SOF] = 1'b1;
      end else begin
        x_cur     = (&x_q) ? x_q : x_q + X_WIDTH'(1);
        x_d       = x_cur;
        line_beat = 1'b1;
      end
      if (line_beat && s_axi4s_tlast) begin
        if (x_cur != w_cur) err_set[ERR_LINE_LEN] = 1'b1;
        x_d = '0;
        y_d = y_cur + Y_WIDTH'(1);
        if (y_cur == h_cur - Y_WIDTH'(1)) begin
          frame_end = 1'b1;
          state_d   = WAIT_SOF;
        end
      end
    end
    // A new error in the same cycle as clear_err survives the clear.
    err_d = (clear_err ? '0 : err_q) | err_set;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= WAIT_SOF;
      x_q      <= '0;
      y_q      <= '0;
      w_q      <= '0;
      h_q      <= '0;
      tready_q <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
      err_q    <= '0;
    end else if (aclken) begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      w_q      <= w_d;
      h_q      <= h_d;
      tready_q <= 1'b1;
      done_q   <= frame_end;
      err_q    <= err_d;
      if (frame_end) count_q <= count_q + FRAME_WIDTH'(1);
    end
  end

  assign s_axi4s_tready = tready_q;
  assign frame_done     = done_q;
  assign frame_count    = count_q;
  assign err_status     = err_q;

`ifdef VIDEO_FRAME_CHECKER_CHECKSUM_EN
  video_frame_checksum #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_checksum (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .beat_i      (beat),
    .sof_i       (sof),
    .frame_end_i (frame_end),
    .tdata_i     (s_axi4s_tdata),
    .checksum_o  (frame_checksum)
  );
`else
  logic unused_tdata;
  assign unused_tdata   = ^s_axi4s_tdata;
  assign frame_checksum = '0;
`endif

endmodule

// File: tb/tb_video_axi4s_frame_checker.sv
// Scoreboard bench for video_axi4s_frame_checker: directed frames, monitor pops on frame_done.
module tb_video_axi4s_frame_checker;

  logic        aclk = 1'b0;
  logic        aresetn, aclken, clear_err;
  logic [11:0] param_width;
  logic [11:0] param_height;
  logic [0:0]  s_axi4s_tuser;
  logic        s_axi4s_tlast, s_axi4s_tvalid, s_axi4s_tready;
  logic [23:0] s_axi4s_tdata;
  logic        frame_done;
  logic [31:0] frame_count;
  logic [2:0]  err_status;
  logic [31:0] frame_checksum;

  video_axi4s_frame_checker dut (
    .aresetn        (aresetn),
    .aclk           (aclk),
    .aclken         (aclken),
    .param_width    (param_width),
    .param_height   (param_height),
    .clear_err      (clear_err),
    .s_axi4s_tuser  (s_axi4s_tuser),
    .s_axi4s_tlast  (s_axi4s_tlast),
    .s_axi4s_tdata  (s_axi4s_tdata),
    .s_axi4s_tvalid (s_axi4s_tvalid),
    .s_axi4s_tready (s_axi4s_tready),
    .frame_done     (frame_done),
    .frame_count    (frame_count),
    .err_status     (err_status),
    .frame_checksum (frame_checksum)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] cnt;
    logic [31:0] sum;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          passes = 0;
  logic [31:0] exp_cnt = 0;
  logic [31:0] run_sum = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic [31:0] csum_exp(input logic [31:0] s);
`ifdef VIDEO_FRAME_CHECKER_CHECKSUM_EN
    return s;
`else
    return 32'd0 & s;
`endif
  endfunction

  always @(negedge aclk) begin
    exp_t e;
    if (aresetn === 1'b1 && frame_done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_frame_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("frame_count", frame_count, e.cnt);
        check("frame_checksum", frame_checksum, e.sum);
      end
    end
  end

  task automatic beat(input logic sof, input logic last, input logic [23:0] d);
    @(negedge aclk);
    aclken         = 1'b1;
    s_axi4s_tvalid = 1'b1;
    s_axi4s_tuser  = sof;
    s_axi4s_tlast  = last;
    s_axi4s_tdata  = d;
    if (sof) run_sum = 0;
    run_sum += 32'(d);
  endtask

  task automatic idle(input int n);
    @(negedge aclk);
    aclken = 1'b1; s_axi4s_tvalid = 1'b0; s_axi4s_tuser = 1'b0; s_axi4s_tlast = 1'b0;
    repeat (n) @(negedge aclk);
  endtask

  // Complete frame; line short_line carries short_len pixels instead of w.
  task automatic frame(input int w, input int h, input int short_line, input int short_len, input int d0);
    int k, n;
    k = 0;
    for (int l = 0; l < h; l++) begin
      n = (l == short_line) ? short_len : w;
      for (int p = 0; p < n; p++) begin
        beat(l == 0 && p == 0, p == n - 1, 24'(d0 + k));
        k++;
        if (l == h - 1 && p == n - 1) begin
          exp_cnt++;
          sb.push_back('{cnt: exp_cnt, sum: csum_exp(run_sum)});
        end
      end
    end
    idle(0);
  endtask

  task automatic partial(input int n, input int w);
    for (int i = 0; i < n; i++) beat(i == 0, (i % w) == w - 1, 24'(100 + i));
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (sb.size() != 0 && i < 20) begin @(negedge aclk); i++; end
    check("scoreboard_drain", sb.size(), 0);
  endtask

  task automatic pulse_clear();
    @(negedge aclk); clear_err = 1'b1;
    @(negedge aclk); clear_err = 1'b0;
    check("err_after_clear", 32'(err_status), 0);
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0; s_axi4s_tvalid = 1'b0;
    #1;
    check("rst_tready", 32'(s_axi4s_tready), 0);
    check("rst_count", frame_count, 0);
    check("rst_err", 32'(err_status), 0);
    sb.delete(); exp_cnt = 0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    idle(2);
  endtask

  initial begin
    aresetn = 1'b0; aclken = 1'b0; clear_err = 1'b0;
    param_width = 12'd4; param_height = 12'd3;
    s_axi4s_tuser = 1'b0; s_axi4s_tlast = 1'b0; s_axi4s_tvalid = 1'b0; s_axi4s_tdata = '0;
    repeat (3) @(negedge aclk);
    check("reset_tready", 32'(s_axi4s_tready), 0);
    check("reset_done", 32'(frame_done), 0);
    check("reset_count", frame_count, 0);
    check("reset_err", 32'(err_status), 0);
    check("reset_checksum", frame_checksum, 0);
    aresetn = 1'b1;
    idle(2);
    check("tready_after_release", 32'(s_axi4s_tready), 1);

    // Two clean 4x3 frames.
    frame(4, 3, -1, 0, 1);
    frame(4, 3, -1, 0, 1);
    drain();
    check("clean_count", frame_count, 2);
    check("clean_err", 32'(err_status), 0);

    // Line 1 is three pixels long; frame still ends on the third tlast.
    frame(4, 3, 1, 3, 20);
    drain();
    check("linelen_err", 32'(err_status), 3'b100);
    check("linelen_count", frame_count, 3);
    pulse_clear();

    // Missing SOF after reset.
    do_reset();
    beat(1'b0, 1'b0, 24'd5);
    beat(1'b0, 1'b1, 24'd6);
    frame(4, 3, -1, 0, 30);
    drain();
    check("nosof_err", 32'(err_status), 3'b001);
    check("nosof_count", frame_count, 1);
    pulse_clear();

    // SOF in the middle of line 2 restarts the frame.
    partial(10, 4);
    frame(4, 3, -1, 0, 50);
    drain();
    check("earlysof_err", 32'(err_status), 3'b010);
    check("earlysof_count", frame_count, 2);
    pulse_clear();

    // 2x2 frame with data 1..4.
    @(negedge aclk); param_width = 12'd2; param_height = 12'd2;
    frame(2, 2, -1, 0, 1);
    drain();
    check("csum_2x2", frame_checksum, csum_exp(32'd10));
    check("csum_2x2_err", 32'(err_status), 0);

    // aclken low with a valid SOF+tlast pending must not advance anything, then a 1x1 frame.
    @(negedge aclk); param_width = 12'd1; param_height = 12'd1;
    aclken = 1'b0; s_axi4s_tvalid = 1'b1; s_axi4s_tuser = 1'b1; s_axi4s_tlast = 1'b1;
    s_axi4s_tdata = 24'd99;
    repeat (3) @(negedge aclk);
    check("stall_count", frame_count, 3);
    frame(1, 1, -1, 0, 7);
    drain();
    check("one_by_one_count", frame_count, 4);
    check("one_by_one_err", 32'(err_status), 0);

    // Reset at pixel 5, then a clean frame.
    @(negedge aclk); param_width = 12'd4; param_height = 12'd3;
    partial(5, 4);
    do_reset();
    frame(4, 3, -1, 0, 60);
    drain();
    check("midrst_count", frame_count, 1);
    check("midrst_err", 32'(err_status), 0);

    idle(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/video_axi4s_frame_checker.md
VIDEO_AXI4S_FRAME_CHECKER -- requirements
Module: video_axi4s_frame_checker

Interface
REQ-001 Parameters SHALL be:
- TUSER_WIDTH, default 1: tuser width; bit 0 marks start of frame (SOF).
- DATA_WIDTH, default 24: tdata width.
- X_WIDTH, default 12: width of the pixel counter and param_width.
- Y_WIDTH, default 12: width of the line counter and param_height.
- FRAME_WIDTH, default 32: width of the frame counter.
REQ-002 Ports SHALL be:
- aresetn  in  1: asynchronous, active-low reset.
- aclk  in  1: the single clock.
- aclken  in  1: clock enable; when low, all state holds.
- param_width  in  X_WIDTH: expected pixels per line; must be at least 1.
- param_height  in  Y_WIDTH: expected lines per frame; must be at least 1.
- clear_err  in  1: one-cycle pulse that clears err_status.
- s_axi4s_tuser  in  TUSER_WIDTH: start-of-frame marker.
- s_axi4s_tlast  in  1: end-of-line marker.
- s_axi4s_tdata  in  DATA_WIDTH: pixel data.
- s_axi4s_tvalid  in  1: pixel valid.
- s_axi4s_tready  out  1: ready to accept a pixel.
- frame_done  out  1: one-cycle pulse when a frame completes.
- frame_count  out  FRAME_WIDTH: number of completed frames.
- err_status  out  3: sticky error flags.
- frame_checksum  out  32: sum of tdata over the last completed frame.

Function
REQ-003 A beat SHALL occur when aclken, s_axi4s_tvalid and s_axi4s_tready are all high; nothing else advances state.
REQ-004 s_axi4s_tready SHALL be a register that is 0 in reset and 1 from the first aclken cycle after reset release; the block never back-pressures.
REQ-005 The state machine SHALL have two states, WAIT_SOF (reset state) and ACTIVE.
REQ-006 A beat with tuser[0]=1 in either state SHALL:
- latch param_width and param_height;
- set x to 1 and y to 0;
- enter ACTIVE.
REQ-007 In WAIT_SOF, a beat with tuser[0]=0 SHALL be discarded and SHALL set err_status[0] (missing SOF).
REQ-008 In ACTIVE, a tuser[0]=1 beat that arrives before frame end SHALL set err_status[1] (early SOF) and restart the frame as in REQ-006.
REQ-009 In ACTIVE, each non-SOF beat SHALL increment x; x saturates at all-ones.
REQ-010 On a beat with tlast=1, err_status[2] (line length) SHALL be set if x, including this beat, differs from the latched width. Then x resets to 0 and y increments.
REQ-011 A tlast beat with y equal to the latched height minus 1 SHALL end the frame:
- pulse frame_done one cycle after the beat;
- increment frame_count, wrapping modulo 2^FRAME_WIDTH;
- return to WAIT_SOF.
REQ-012 A beat that is both SOF and tlast SHALL be treated as a one-pixel line, so a 1x1 frame completes on that beat.
REQ-013 err_status bits SHALL be sticky. When a set condition and clear_err occur in the same cycle, the set SHALL win.
REQ-014 All outputs SHALL be registered; frame_done, frame_count and frame_checksum SHALL update together, one cycle after the final beat.

Reset
REQ-015 Assertion of aresetn SHALL immediately:
- zero s_axi4s_tready, frame_done, frame_count, err_status, frame_checksum, x and y;
- force WAIT_SOF.
REQ-016 Reset asserted mid-frame SHALL discard the partial frame; the next frame must begin with SOF.

Configuration
REQ-017 With VIDEO_FRAME_CHECKER_CHECKSUM_EN defined:
- a 32-bit accumulator SHALL sum zero-extended tdata modulo 2^32 over all beats from SOF to frame end;
- the accumulator restarts at each SOF;
- the sum is copied to frame_checksum at frame end.
REQ-018 Without VIDEO_FRAME_CHECKER_CHECKSUM_EN, frame_checksum SHALL be constant 0 and no accumulator logic SHALL exist.

Structure
REQ-019 A shared package video_checker_pkg SHALL hold:
- the state enum (WAIT_SOF, ACTIVE);
- the error-bit index constants ERR_NO_SOF=0, ERR_EARLY_SOF=1, ERR_LINE_LEN=2.
REQ-020 Checksum accumulation SHALL live in sub-module video_frame_checksum, instantiated only under the macro; everything else stays flat.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Width 4, height 3, a clean 4x3 frame sent twice: frame_done pulses twice, frame_count is 2, err_status is 000.
- A 4x3 frame whose line 1 asserts tlast at pixel 3: err_status[2]=1, and the frame still completes on the third tlast.
- Two beats with no SOF after reset, then a clean frame: err_status[0]=1, frame_count is 1; a clear_err pulse then gives 000.
- SOF re-asserted in the middle of line 2: err_status[1]=1, the new frame completes normally, frame_count increments once.
- With the macro defined, a 2x2 frame with tdata 1, 2, 3, 4: frame_checksum is 10. Without the macro, frame_checksum stays 0.
- Reset asserted at pixel 5 of a frame, then a clean frame: frame_count is 1, err_status is 000.
